// File: rtl/div_ctrl_pkg.sv
// Shared types and the ratio-index to div_sel mapping for the divider control path.
package div_ctrl_pkg;

  localparam int STAGE_NUM_DEF = 4;
  localparam int MAX_SEL_W     = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CHECK = 2'd1;
  localparam state_t ST_STEP  = 2'd2;
  localparam state_t ST_DWELL = 2'd3;

  // Index 0 selects the undivided clock; k>=1 sets the MSB and encodes k-1 below it.
  function automatic logic [MAX_SEL_W-1:0] idx_to_sel(input logic [MAX_SEL_W-1:0] k,
                                                      input int sel_w);
    logic [MAX_SEL_W-1:0] msb;
    msb = MAX_SEL_W'(1) << (sel_w - 1);
    if (k == '0) return '0;
    return msb | (k - MAX_SEL_W'(1));
  endfunction

endpackage

// File: rtl/div_sel_sequencer.sv
// Steps the ripple divider's div_sel toward a requested ratio with a dwell after each change.
// Define DIV_SEQ_DIRECT_JUMP_EN to jump straight to the target in a single step.
module div_sel_sequencer
  import div_ctrl_pkg::*;
#(
  parameter int STAGE_NUM    = STAGE_NUM_DEF,
  parameter int SEL_W        = $clog2(STAGE_NUM) + 1,
  parameter int DWELL_CYCLES = 8,
  parameter int RESET_IDX    = 0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_idx,
  output logic [SEL_W-1:0] div_sel,
  output logic [SEL_W-1:0] cur_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

  localparam logic [SEL_W-1:0] MAX_IDX    = SEL_W'(STAGE_NUM);
  localparam logic [SEL_W-1:0] RESET_IDXV = SEL_W'(RESET_IDX);
  localparam logic [SEL_W-1:0] RESET_SEL  =
    SEL_W'(idx_to_sel(MAX_SEL_W'(RESET_IDX), SEL_W));
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q,   state_d;
  logic [SEL_W-1:0] target_q,  target_d;
  logic [SEL_W-1:0] cur_idx_q, cur_idx_d;
  logic [SEL_W-1:0] div_sel_q, div_sel_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             reject_q,  reject_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;

  // Null and rejected requests pass through a zero-length dwell so their
  // response lands one cycle after CHECK, matching the stepping path.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_idx_d = cur_idx_q;
    cnt_d     = cnt_q;
    reject_d  = reject_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_idx;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (target_q > MAX_IDX) begin
          reject_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_DWELL;
        end else if (target_q == cur_idx_q) begin
          reject_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_DWELL;
        end else begin
          reject_d = 1'b0;
          state_d  = ST_STEP;
        end
      end
      ST_STEP: begin
`ifdef DIV_SEQ_DIRECT_JUMP_EN
        cur_idx_d = target_q;
`else
        if (cur_idx_q < target_q) cur_idx_d = cur_idx_q + SEL_W'(1);
        else                      cur_idx_d = cur_idx_q - SEL_W'(1);
`endif
        cnt_d   = DWELL_LOAD;
        state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (reject_q) begin
          reject_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (cur_idx_q != target_q) begin
          state_d = ST_STEP;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    div_sel_d = SEL_W'(idx_to_sel(MAX_SEL_W'(cur_idx_d), SEL_W));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= RESET_IDXV;
      cur_idx_q <= RESET_IDXV;
      div_sel_q <= RESET_SEL;
      cnt_q     <= '0;
      reject_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_idx_q <= cur_idx_d;
      div_sel_q <= div_sel_d;
      cnt_q     <= cnt_d;
      reject_q  <= reject_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign div_sel   = div_sel_q;
  assign cur_idx   = cur_idx_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_div_sel_sequencer.sv
// Directed bench for div_sel_sequencer (STAGE_NUM=4, DWELL_CYCLES=8, RESET_IDX=0).
// Covers both stepping and DIV_SEQ_DIRECT_JUMP_EN builds.
module tb_div_sel_sequencer;

  localparam int SEL_W = 3;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_idx;
  logic [SEL_W-1:0] div_sel;
  logic [SEL_W-1:0] cur_idx;
  logic             busy;
  logic             done;
  logic             err;

  int passed = 0;
  int total  = 0;

  div_sel_sequencer #(
    .STAGE_NUM   (4),
    .SEL_W       (SEL_W),
    .DWELL_CYCLES(8),
    .RESET_IDX   (0)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_idx  (req_idx),
    .div_sel  (div_sel),
    .cur_idx  (cur_idx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present a request for one edge (edge N); returns just after edge N.
  task automatic apply_request(input int idx, input bit hold);
    req_valid = 1'b1;
    req_idx   = SEL_W'(idx);
    tick(1);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    tick(2);
    check_output("rst_div_sel", 32'(div_sel), 0);
    check_output("rst_cur_idx", 32'(cur_idx), 0);
    check_output("rst_ready",   32'(req_ready), 1);
    check_output("rst_busy",    32'(busy), 0);
    check_output("rst_done",    32'(done), 0);
    check_output("rst_err",     32'(err), 0);
    rst_n = 1'b1;
    tick(1);

`ifdef DIV_SEQ_DIRECT_JUMP_EN
    $display("[TB] direct jump 0 -> 3");
    apply_request(3, 1'b0);
    tick(1);
    check_output("dj_n1_div_sel", 32'(div_sel), 0);
    tick(1);
    check_output("dj_n2_div_sel", 32'(div_sel), 6);
    tick(7);
    check_output("dj_n9_done", 32'(done), 0);
    check_output("dj_n9_div_sel", 32'(div_sel), 6);
    tick(1);
    check_output("dj_n10_done", 32'(done), 1);
    check_output("dj_n10_cur", 32'(cur_idx), 3);
    tick(1);
    check_output("dj_n11_done", 32'(done), 0);
    check_output("dj_n11_ready", 32'(req_ready), 1);
`else
    $display("[TB] step 0 -> 3");
    apply_request(3, 1'b0);
    check_output("up_n0_busy", 32'(busy), 1);
    tick(1);
    check_output("up_n1_div_sel", 32'(div_sel), 0);
    tick(1);
    check_output("up_n2_div_sel", 32'(div_sel), 4);
    tick(8);
    check_output("up_n10_div_sel", 32'(div_sel), 4);
    tick(1);
    check_output("up_n11_div_sel", 32'(div_sel), 5);
    tick(8);
    check_output("up_n19_div_sel", 32'(div_sel), 5);
    tick(1);
    check_output("up_n20_div_sel", 32'(div_sel), 6);
    tick(7);
    check_output("up_n27_done", 32'(done), 0);
    check_output("up_n27_busy", 32'(busy), 1);
    tick(1);
    check_output("up_n28_done", 32'(done), 1);
    check_output("up_n28_err",  32'(err), 0);
    check_output("up_n28_cur",  32'(cur_idx), 3);
    tick(1);
    check_output("up_n29_done",  32'(done), 0);
    check_output("up_n29_ready", 32'(req_ready), 1);

    $display("[TB] step 3 -> 1");
    apply_request(1, 1'b0);
    tick(2);
    check_output("dn_n2_div_sel", 32'(div_sel), 5);
    tick(8);
    check_output("dn_n10_div_sel", 32'(div_sel), 5);
    tick(1);
    check_output("dn_n11_div_sel", 32'(div_sel), 4);
    tick(7);
    check_output("dn_n18_done", 32'(done), 0);
    tick(1);
    check_output("dn_n19_done", 32'(done), 1);
    check_output("dn_n19_cur",  32'(cur_idx), 1);
    tick(1);

    $display("[TB] out-of-range request");
    apply_request(5, 1'b0);
    tick(1);
    check_output("er_n1_err", 32'(err), 0);
    tick(1);
    check_output("er_n2_err",     32'(err), 1);
    check_output("er_n2_done",    32'(done), 0);
    check_output("er_n2_div_sel", 32'(div_sel), 4);
    tick(1);
    check_output("er_n3_err", 32'(err), 0);
    check_output("er_n3_cur", 32'(cur_idx), 1);

    $display("[TB] null request with req_valid held");
    apply_request(1, 1'b1);
    tick(1);
    check_output("eq_n1_busy", 32'(busy), 1);
    check_output("eq_n1_done", 32'(done), 0);
    tick(1);
    check_output("eq_n2_done",    32'(done), 1);
    check_output("eq_n2_div_sel", 32'(div_sel), 4);
    check_output("eq_n2_ready",   32'(req_ready), 1);
    tick(1);
    req_valid = 1'b0;
    check_output("eq_n3_busy", 32'(busy), 1);
    check_output("eq_n3_done", 32'(done), 0);
    tick(2);
    check_output("eq_n5_done", 32'(done), 1);
    tick(1);

    $display("[TB] reset during dwell");
    apply_request(4, 1'b0);
    tick(2);
    check_output("rd_n2_div_sel", 32'(div_sel), 5);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_output("rd_div_sel", 32'(div_sel), 0);
    check_output("rd_cur",     32'(cur_idx), 0);
    check_output("rd_busy",    32'(busy), 0);
    check_output("rd_ready",   32'(req_ready), 1);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check_output("rd_post_div_sel", 32'(div_sel), 0);
    check_output("rd_post_done",    32'(done), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
